// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus a four-state handshake sequencer that sits in
// front of a UART transmitter. Bytes written on the clk domain are buffered and
// released one at a time. A byte is released only after the UART has
// acknowledged the previous one. Every handshake towards the UART is held at a
// steady level until the UART acknowledges it, because the UART transmitter
// runs off a slower baud-derived clock.
module uart_tx_feeder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  busy,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    output logic                  tx_complete_del_flag,
    input  logic                  tx_busy,
    input  logic                  tx_complete_flag
);

    localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_DONE,
        ST_CLEAR
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizers for the UART status lines.
    // Bit 0 is tx_busy and bit 1 is tx_complete_flag.
    // ------------------------------------------------------------------
    logic [1:0] async_in;
    logic [1:0] sync_out;
    logic       s_busy;
    logic       s_done;

    assign async_in = {tx_complete_flag, tx_busy};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic out_reg;

            // Two-stage synchronizer for one status line
            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_reg <= 1'b0;
                    out_reg  <= 1'b0;
                end else begin
                    meta_reg <= async_in[gi];
                    out_reg  <= meta_reg;
                end
            end

            assign sync_out[gi] = out_reg;
        end
    endgenerate

    assign s_busy = sync_out[0];
    assign s_done = sync_out[1];

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  full_reg;
    logic                  empty_reg;
    logic                  overflow_reg;

    state_t                state_reg;
    logic                  tx_start_reg;
    logic                  del_flag_reg;
    logic [7:0]            tx_data_reg;

    logic                  push;
    logic                  pop;

    // A push is judged on the registered full flag only.
    // A pop freeing a slot in the same cycle does not admit a write into a full FIFO.
    assign push = wr_en & ~full_reg;

    // A byte is issued only from IDLE, with no stale done flag and the UART idle
    assign pop  = (state_reg == ST_IDLE) & ~s_done & ~s_busy & ~empty_reg;

    // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage write port; no reset so the array can map onto block RAM
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers, registered occupancy flags and the sticky overflow indicator
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == FULL_COUNT);
            empty_reg <= (count_next == '0);
            if (wr_en && full_reg) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake sequencer. tx_start and the delete flag are registered
    // copies of the state being entered, so they never glitch.
    // ------------------------------------------------------------------
    // Sequencer state, registered handshake outputs and the tx_data holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            tx_start_reg <= 1'b0;
            del_flag_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (s_done) begin
                        // Stale done flag (e.g. after reset): clear it before issuing anything
                        state_reg    <= ST_CLEAR;
                        del_flag_reg <= 1'b1;
                        tx_start_reg <= 1'b0;
                    end else if (pop) begin
                        state_reg    <= ST_START;
                        tx_start_reg <= 1'b1;
                        tx_data_reg  <= mem[rd_ptr_reg];
                    end
                end
                ST_START: begin
                    // No timeout: a UART that never raises busy parks here until reset
                    if (s_busy) begin
                        state_reg    <= ST_WAIT_DONE;
                        tx_start_reg <= 1'b0;
                    end
                end
                ST_WAIT_DONE: begin
                    if (s_done) begin
                        state_reg    <= ST_CLEAR;
                        del_flag_reg <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (!s_done) begin
                        state_reg    <= ST_IDLE;
                        del_flag_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    tx_start_reg <= 1'b0;
                    del_flag_reg <= 1'b0;
                end
            endcase
        end
    end

    assign full                 = full_reg;
    assign empty                = empty_reg;
    assign count                = count_reg;
    assign overflow             = overflow_reg;
    assign busy                 = (state_reg != ST_IDLE);
    assign tx_data              = tx_data_reg;
    assign tx_start             = tx_start_reg;
    assign tx_complete_del_flag = del_flag_reg;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: drives uart_tx_feeder with directed and random traffic.
// A behavioural UART (runs on negedge) accepts each tx_start, records the byte,
// raises busy, then raises a sticky done flag that it drops once the delete
// flag is seen. Expected streams and handshake timing come from the bench.
module tb_uart_tx_feeder;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [7:0]          wr_data;
    logic                wr_en;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                busy;
    logic [7:0]          tx_data;
    logic                tx_start;
    logic                tx_complete_del_flag;
    logic                tx_busy;
    logic                tx_complete_flag;

    logic m_busy, m_done, force_busy, force_done;
    assign tx_busy          = m_busy | force_busy;
    assign tx_complete_flag = m_done | force_done;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   uart_auto   = 1'b0;
    bit   rand_timing = 1'b0;
    int   busy_delay = 3, busy_len = 4, clr_delay = 2;
    int   busy_rise_cyc = 0, done_rise_cyc = 0, done_fall_cyc = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    uart_tx_feeder #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk                  (clk),
        .reset                (reset),
        .wr_data              (wr_data),
        .wr_en                (wr_en),
        .full                 (full),
        .empty                (empty),
        .count                (count),
        .overflow             (overflow),
        .busy                 (busy),
        .tx_data              (tx_data),
        .tx_start             (tx_start),
        .tx_complete_del_flag (tx_complete_del_flag),
        .tx_busy              (tx_busy),
        .tx_complete_flag     (tx_complete_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural UART: one transaction per accepted tx_start
    initial begin
        int d, l, c;
        m_busy = 1'b0;
        m_done = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_auto && tx_start === 1'b1 && !m_busy && !m_done) begin
                rx_q.push_back(tx_data);
                $display("uart rx byte %02h at cycle %0d", tx_data, cyc);
                d = rand_timing ? int'($urandom_range(0, 4)) : busy_delay;
                l = rand_timing ? int'($urandom_range(1, 6)) : busy_len;
                c = rand_timing ? int'($urandom_range(0, 3)) : clr_delay;
                repeat (d) @(negedge clk);
                m_busy = 1'b1;
                busy_rise_cyc = cyc;
                repeat (l) @(negedge clk);
                m_busy = 1'b0;
                m_done = 1'b1;
                done_rise_cyc = cyc;
                for (int k = 0; k < 100 && tx_complete_del_flag !== 1'b1; k++) @(negedge clk);
                repeat (c) @(negedge clk);
                m_done = 1'b0;
                done_fall_cyc = cyc;
            end
        end
    end

    // Wait until n bytes were received and both sides are idle again
    task automatic wait_drain(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (rx_q.size() >= n && busy === 1'b0 && !m_busy && !m_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // 1: reset values, then reset with FIFO half full and FSM in START
    task automatic test_reset;
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
        force_busy = 1'b0; force_done = 1'b0;
        @(negedge clk);
        total++; if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || overflow !== 1'b0) begin
            bad++; $display("FAIL reset_fifo: got empty=%b full=%b count=%0d ovf=%b want 1 0 0 0", empty, full, count, overflow); end
        total++; if (busy !== 1'b0 || tx_start !== 1'b0 || tx_complete_del_flag !== 1'b0 || tx_data !== 8'h00) begin
            bad++; $display("FAIL reset_fsm: got busy=%b start=%b del=%b data=%h want 0 0 0 00", busy, tx_start, tx_complete_del_flag, tx_data); end
        reset = 1'b0;
        uart_auto = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        @(negedge clk);
        total++; if (count !== 5'd7 || tx_start !== 1'b1 || busy !== 1'b1 || tx_data !== 8'h10) begin
            bad++; $display("FAIL pre_reset: got count=%0d start=%b busy=%b data=%h want 7 1 1 10", count, tx_start, busy, tx_data); end
        do_reset();
        total++; if (count !== 5'd0 || empty !== 1'b1 || tx_start !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
            bad++; $display("FAIL midframe_reset: got count=%0d empty=%b start=%b busy=%b data=%h want 0 1 0 0 00", count, empty, tx_start, busy, tx_data); end
    endtask

    // 2: single byte A5, exact latency and handshake timing
    task automatic test_single;
        int start_fall, del_rise, del_fall;
        bit done_ok;
        start_fall = -1; del_rise = -1; del_fall = -1; done_ok = 1'b0;
        rx_q.delete();
        uart_auto = 1'b1; rand_timing = 1'b0;
        busy_delay = 3; busy_len = 4; clr_delay = 2;
        wr_data = 8'hA5; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        total++; if (empty !== 1'b0 || count !== 5'd1 || tx_start !== 1'b0) begin
            bad++; $display("FAIL write_latency: got empty=%b count=%0d start=%b want 0 1 0", empty, count, tx_start); end
        @(negedge clk);
        total++; if (tx_start !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1 || empty !== 1'b1) begin
            bad++; $display("FAIL pop_latency: got start=%b data=%h busy=%b empty=%b want 1 a5 1 1", tx_start, tx_data, busy, empty); end
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (start_fall < 0 && tx_start === 1'b0) start_fall = cyc;
            if (del_rise < 0 && tx_complete_del_flag === 1'b1) del_rise = cyc;
            if (del_rise >= 0 && tx_complete_del_flag === 1'b0) begin
                del_fall = cyc; done_ok = 1'b1; break;
            end
        end
        total++; if (!done_ok) begin
            bad++; $display("FAIL single_timeout: got del_fall=%0d want completion within 200 cycles", del_fall); end
        total++; if (start_fall - busy_rise_cyc !== 3) begin
            bad++; $display("FAIL start_hold: got %0d cycles from busy to start low want 3", start_fall - busy_rise_cyc); end
        total++; if (del_rise - done_rise_cyc !== 3) begin
            bad++; $display("FAIL del_rise: got %0d cycles from done to del high want 3", del_rise - done_rise_cyc); end
        total++; if (del_fall - done_fall_cyc !== 3 || busy !== 1'b0) begin
            bad++; $display("FAIL del_fall: got %0d cycles busy=%b want 3 cycles busy=0", del_fall - done_fall_cyc, busy); end
        total++; if (rx_q.size() !== 1 || tx_data !== 8'hA5) begin
            bad++; $display("FAIL single_data: got rx=%0d tx_data=%h want 1 a5", rx_q.size(), tx_data); end
        else begin
            total++; if (rx_q[0] !== 8'hA5) begin
                bad++; $display("FAIL single_rx: got %h want a5", rx_q[0]); end
        end
    endtask

    // 3: fill to 16 with UART stalled, overflow on 17th, drain in order
    task automatic test_fill_overflow;
        bit ok;
        rx_q.delete();
        force_busy = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        total++; if (count !== 5'd16 || full !== 1'b1 || empty !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL fill: got count=%0d full=%b empty=%b ovf=%b want 16 1 0 0", count, full, empty, overflow); end
        wr_en = 1'b1; wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0;
        total++; if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
            bad++; $display("FAIL overflow: got ovf=%b count=%0d full=%b want 1 16 1", overflow, count, full); end
        force_busy = 1'b0;
        wait_drain(DEPTH, 3000, ok);
        total++; if (!ok || rx_q.size() !== DEPTH) begin
            bad++; $display("FAIL drain16: got ok=%b rx=%0d want 1 16", ok, rx_q.size()); end
        else begin
            for (int i = 0; i < DEPTH; i++) begin
                total++; if (rx_q[i] !== 8'(i)) begin
                    bad++; $display("FAIL order[%0d]: got %h want %h", i, rx_q[i], 8'(i)); end
            end
        end
        total++; if (overflow !== 1'b1 || empty !== 1'b1) begin
            bad++; $display("FAIL sticky_ovf: got ovf=%b empty=%b want 1 1", overflow, empty); end
    endtask

    // 4: push and pop on the same edge at count 5
    task automatic test_push_pop;
        bit ok;
        rx_q.delete();
        force_busy = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hB0 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        total++; if (count !== 5'd5) begin
            bad++; $display("FAIL count5: got %0d want 5", count); end
        force_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (count !== 5'd5 || tx_start !== 1'b0) begin
            bad++; $display("FAIL before_pop: got count=%0d start=%b want 5 0", count, tx_start); end
        wr_en = 1'b1; wr_data = 8'hB5;
        @(negedge clk);
        wr_en = 1'b0;
        total++; if (count !== 5'd5 || tx_start !== 1'b1 || tx_data !== 8'hB0) begin
            bad++; $display("FAIL push_pop: got count=%0d start=%b data=%h want 5 1 b0", count, tx_start, tx_data); end
        wait_drain(6, 3000, ok);
        total++; if (!ok || rx_q.size() !== 6) begin
            bad++; $display("FAIL drain6: got ok=%b rx=%0d want 1 6", ok, rx_q.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                total++; if (rx_q[i] !== 8'(8'hB0 + i)) begin
                    bad++; $display("FAIL pp_order[%0d]: got %h want %h", i, rx_q[i], 8'(8'hB0 + i)); end
            end
        end
    endtask

    // 5: stale done flag held out of reset
    task automatic test_stale_done;
        int drop_cyc, del_fall, start_rise;
        bit ok;
        del_fall = -1; start_rise = -1;
        rx_q.delete();
        force_done = 1'b1;
        do_reset();
        total++; if (tx_complete_del_flag !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL stale_reset: got del=%b busy=%b ovf=%b want 0 0 0", tx_complete_del_flag, busy, overflow); end
        repeat (4) @(negedge clk);
        total++; if (tx_complete_del_flag !== 1'b1 || busy !== 1'b1 || tx_start !== 1'b0) begin
            bad++; $display("FAIL stale_clear: got del=%b busy=%b start=%b want 1 1 0", tx_complete_del_flag, busy, tx_start); end
        wr_en = 1'b1; wr_data = 8'h5A;
        @(negedge clk);
        wr_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++; if (tx_start !== 1'b0 || tx_complete_del_flag !== 1'b1) begin
                bad++; $display("FAIL stale_hold: got start=%b del=%b want 0 1", tx_start, tx_complete_del_flag); end
        end
        force_done = 1'b0;
        drop_cyc = cyc;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (del_fall < 0 && tx_complete_del_flag === 1'b0) del_fall = cyc;
            if (tx_start === 1'b1) begin start_rise = cyc; break; end
        end
        total++; if (del_fall - drop_cyc !== 3) begin
            bad++; $display("FAIL stale_del_fall: got %0d want 3", del_fall - drop_cyc); end
        total++; if (start_rise - drop_cyc !== 4) begin
            bad++; $display("FAIL stale_start: got %0d want 4", start_rise - drop_cyc); end
        wait_drain(1, 500, ok);
        total++; if (!ok || rx_q.size() !== 1) begin
            bad++; $display("FAIL stale_drain: got ok=%b rx=%0d want 1 1", ok, rx_q.size()); end
        else begin
            total++; if (rx_q[0] !== 8'h5A) begin
                bad++; $display("FAIL stale_data: got %h want 5a", rx_q[0]); end
        end
    endtask

    // 6: 64 random bytes with random gaps and random UART timing
    task automatic test_random_stream;
        bit ok;
        bit room_ok;
        logic [7:0] b;
        room_ok = 1'b1;
        do_reset();
        rx_q.delete(); exp_q.delete();
        uart_auto = 1'b1; rand_timing = 1'b1;
        for (int n = 0; n < 64; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            for (int g = 0; g < 5000 && (n - rx_q.size()) >= DEPTH; g++) @(negedge clk);
            if ((n - rx_q.size()) >= DEPTH) room_ok = 1'b0;
            b = 8'($urandom);
            exp_q.push_back(b);
            wr_en = 1'b1; wr_data = b;
            @(negedge clk);
            wr_en = 1'b0;
        end
        total++; if (!room_ok) begin
            bad++; $display("FAIL rand_room: got stalled writer want room within 5000 cycles"); end
        wait_drain(64, 10000, ok);
        total++; if (!ok || rx_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL rand_drain: got ok=%b rx=%0d want 1 %0d", ok, rx_q.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++; if (rx_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL rand[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
            end
        end
        total++; if (overflow !== 1'b0 || empty !== 1'b1) begin
            bad++; $display("FAIL rand_flags: got ovf=%b empty=%b want 0 1", overflow, empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_push_pop();
        test_stale_done();
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
